regalu_pipe: RTL and testbench
==============================

// Module: regalu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-cycle register-file/ALU datapath.
//  - Holds a 2^ADDRESS_WIDTH-entry register file, an operand-2 mux (register or immediate)
//    and a 10-op ALU.
//  - Registers each result in a write-back stage and writes it back under a valid/ready handshake.
//  - Forwards the pending write-back value to the next operation.
//  - Sits between the control/decode unit (producer) and the PC/branch logic (consumer of eq).
// PARAMETERS
//  DATA_WIDTH     32  register/ALU width; power of 2, >= 8
//  ADDRESS_WIDTH  5   register address width; depth = 2**ADDRESS_WIDTH
//  A0_ADDR        10  register index driven onto a0
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              asynchronous, active-high reset
//  in_valid   in   1              operation present on rs1..ImmOp
//  in_ready   out  1              stage 1 can accept; accept = in_valid & in_ready
//  rs1        in   ADDRESS_WIDTH  source register 1
//  rs2        in   ADDRESS_WIDTH  source register 2
//  rd         in   ADDRESS_WIDTH  destination register
//  RegWrite   in   1              write result to rd at write-back
//  ALUsrc     in   1              0: op2 = reg[rs2]; 1: op2 = ImmOp
//  ALUCtrl    in   4              ALU operation (encoding below)
//  ImmOp      in   DATA_WIDTH     immediate operand
//  out_valid  out  1              write-back stage holds a result
//  out_ready  in   1              consumer accepts; retire = out_valid & out_ready
//  result     out  DATA_WIDTH     registered ALU result
//  eq         out  1              registered (op1 == op2)
//  a0         out  DATA_WIDTH     current contents of reg[A0_ADDR]
// BEHAVIOUR
//  Reset
//  - On rst assertion (asynchronous): all registers = 0; out_valid, result, eq = 0; a0 = 0.
//  - An in-flight result is dropped and never written.
//  Handshake
//  - in_ready = !out_valid | out_ready (combinational; no in_valid -> in_ready path).
//  - Inputs are sampled only on accept.
//  - On accept, the next cycle has out_valid = 1 with that op's result/eq. Latency is 1 cycle.
//  - Throughput is 1 op/cycle while out_ready = 1.
//  - If out_valid & !out_ready: result, eq, rd and we are held stable; in_ready = 0.
//  - Retire without accept -> out_valid = 0. Retire with accept -> stage reloaded, out_valid stays 1.
//  Write-back
//  - On retire with we & rd != 0: reg[rd] <= result at that edge.
//  - Writes to x0 are ignored; reg[0] always reads 0.
//  - a0 reflects reg[A0_ADDR] and changes in the cycle after the write edge.
//  Operand read/forward (stage 1, combinational)
//  - op1 = (rs1 == 0) ? 0 : (out_valid & we & rd_wb == rs1) ? result : reg[rs1].
//  - The same rule gives the rs2 register value.
//  - op2 = ALUsrc ? ImmOp : rs2 value.
//  - Forwarding applies whether or not the pending result retires in the same cycle.
//  ALUCtrl encoding (mod 2^DATA_WIDTH)
//  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
//  - 5 SLT (signed, result 0/1), 6 SLTU (unsigned, result 0/1).
//  - 7 SLL, 8 SRL, 9 SRA: shift amount = op2[$clog2(DATA_WIDTH)-1:0].
//  - 10..15: result = 0. eq is still computed.
//  - No overflow/carry outputs; wrap-around is silent.
// TESTING
//  1. Reset, then idle.
//     -> out_valid = 0, in_ready = 1, a0 = 0, reads of all regs = 0.
//  2. ADD x10 = x0 + imm 5 (ALUsrc = 1, RegWrite = 1), out_ready = 1.
//     -> next cycle out_valid = 1, result = 5; one cycle later a0 = 5.
//  3. Back-to-back ops, out_ready = 1: x1 = x0 + 7, then x2 = x1 + x1 (ALUsrc = 0) in the next cycle.
//     -> second result = 14 via forwarding; reg[2] = 14.
//  4. out_ready = 0 for 3 cycles with result pending.
//     -> in_ready = 0, result/out_valid held stable; new input ignored; out_ready = 1 retires exactly once.
//  5. x3 = 0x8000_0000 SRA 4 -> 0xF800_0000; SLT(-1, 1) -> 1; SLTU(-1, 1) -> 0;
//     SUB(3, 3) -> 0 with eq = 1; op 12 -> result 0.
//  6. Write x0 = 9, then read x0 -> 0.
//     Assert rst while out_valid = 1 (pending rd = 5) -> reg[5] stays 0, out_valid = 0.

Source files
------------

// File: rtl/regalu_pipe_if.sv
// Operation/result handshake bundle between the decode unit, regalu_pipe and its consumer.
// The master side issues operations and accepts results; regalu_pipe is the slave.
interface regalu_pipe_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5
);
    logic                     in_valid;
    logic                     in_ready;
    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic                     RegWrite;
    logic                     ALUsrc;
    logic [3:0]               ALUCtrl;
    logic [DATA_WIDTH-1:0]    ImmOp;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    result;
    logic                     eq;

    modport master (
        output in_valid, rs1, rs2, rd, RegWrite, ALUsrc, ALUCtrl, ImmOp, out_ready,
        input  in_ready, out_valid, result, eq
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, RegWrite, ALUsrc, ALUCtrl, ImmOp, out_ready,
        output in_ready, out_valid, result, eq
    );
endinterface

// File: rtl/regalu_pipe.sv
// Register file + ALU with a single registered write-back stage, valid/ready handshake
// and forwarding of the pending write-back value into operand read.
module regalu_pipe #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned A0_ADDR       = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    regalu_pipe_if.slave          bus,
    output logic [DATA_WIDTH-1:0] a0
);
    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int unsigned SHW   = $clog2(DATA_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(A0_ADDR);

    logic [DATA_WIDTH-1:0]    regs_q [DEPTH];
    logic                     out_valid_q;
    logic                     eq_q;
    logic                     we_q;
    logic [DATA_WIDTH-1:0]    result_q;
    logic [ADDRESS_WIDTH-1:0] rd_q;

    logic                  accept;
    logic                  retire;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [DATA_WIDTH-1:0] alu_d;
    logic [SHW-1:0]        shamt;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign retire        = out_valid_q && bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.eq        = eq_q;
    assign a0            = regs_q[A0_IDX];

    // Pending write-back wins over the register file, whether or not it retires this cycle.
    always_comb begin
        rs1_val = regs_q[bus.rs1];
        if (bus.rs1 == '0) begin
            rs1_val = '0;
        end else if (out_valid_q && we_q && rd_q == bus.rs1) begin
            rs1_val = result_q;
        end
        rs2_val = regs_q[bus.rs2];
        if (bus.rs2 == '0) begin
            rs2_val = '0;
        end else if (out_valid_q && we_q && rd_q == bus.rs2) begin
            rs2_val = result_q;
        end
    end

    always_comb begin
        op1   = rs1_val;
        op2   = bus.ALUsrc ? bus.ImmOp : rs2_val;
        shamt = op2[SHW-1:0];
        alu_d = '0;
        case (bus.ALUCtrl)
            4'd0:    alu_d = op1 + op2;
            4'd1:    alu_d = op1 - op2;
            4'd2:    alu_d = op1 & op2;
            4'd3:    alu_d = op1 | op2;
            4'd4:    alu_d = op1 ^ op2;
            4'd5:    alu_d = DATA_WIDTH'($signed(op1) < $signed(op2));
            4'd6:    alu_d = DATA_WIDTH'(op1 < op2);
            4'd7:    alu_d = op1 << shamt;
            4'd8:    alu_d = op1 >> shamt;
            4'd9:    alu_d = $unsigned($signed(op1) >>> shamt);
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q      <= '{default: '0};
            out_valid_q <= 1'b0;
            result_q    <= '0;
            eq_q        <= 1'b0;
            rd_q        <= '0;
            we_q        <= 1'b0;
        end else begin
            if (retire && we_q && rd_q != '0) begin
                regs_q[rd_q] <= result_q;
            end
            if (accept) begin
                out_valid_q <= 1'b1;
                result_q    <= alu_d;
                eq_q        <= (op1 == op2);
                rd_q        <= bus.rd;
                we_q        <= bus.RegWrite;
            end else if (retire) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regalu_pipe.sv
// Directed bench for regalu_pipe: issued ops push expected result/eq into a scoreboard,
// which is popped and compared whenever the DUT retires a result.
module tb_regalu_pipe;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned A0 = 10;

    typedef struct packed {
        logic [DW-1:0] result;
        logic          eq;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] a0;

    exp_t          sb[$];
    exp_t          e;
    logic [DW-1:0] mregs [32];
    int            checks   = 0;
    int            failures = 0;
    int            retired  = 0;

    always #5 clk = ~clk;

    regalu_pipe_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    regalu_pipe #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .A0_ADDR      (A0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .a0 (a0)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_alu(input logic [3:0] c, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        int unsigned sh;
        sh = int'(b[4:0]);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << sh;
            4'd8:    return a >> sh;
            4'd9:    return $unsigned($signed(a) >>> sh);
            default: return '0;
        endcase
    endfunction

    // Scoreboard consumer: a result is compared in the cycle it retires.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL sb_extra observed=%0h expected=none", bus.result);
            end else begin
                e = sb.pop_front();
                check("sb_result", bus.result, e.result);
                check("sb_eq", {31'd0, bus.eq}, {31'd0, e.eq});
                retired++;
            end
        end
    end

    // Issue one op at posedge+1, wait for its accept edge, return at posedge+1.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we, input logic src, input logic [3:0] ctrl,
                         input logic [DW-1:0] imm, input logic track);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        exp_t          x;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.rd       = rd;
        bus.RegWrite = we;
        bus.ALUsrc   = src;
        bus.ALUCtrl  = ctrl;
        bus.ImmOp    = imm;
        bus.in_valid = 1'b1;
        a = (rs1 == 0) ? '0 : mregs[rs1];
        b = src ? imm : ((rs2 == 0) ? '0 : mregs[rs2]);
        x.result = model_alu(ctrl, a, b);
        x.eq     = (a == b);
        if (track) begin
            sb.push_back(x);
            if (we && rd != 0) mregs[rd] = x.result;
        end
        #1;
        check("in_ready_issue", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] held;
        int            ret0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.rd        = '0;
        bus.RegWrite  = 1'b0;
        bus.ALUsrc    = 1'b0;
        bus.ALUCtrl   = '0;
        bus.ImmOp     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1. reset state, all registers read zero
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_a0", a0, 32'd0);
        for (int i = 0; i < 32; i++) issue(5'(i), 5'(i), 5'd0, 1'b0, 1'b0, 4'd3, '0, 1'b1);
        @(posedge clk); #1;

        // 2. a0 update
        issue(5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 4'd0, 32'd5, 1'b1);
        check("add_imm_valid", {31'd0, bus.out_valid}, 32'd1);
        check("add_imm_result", bus.result, 32'd5);
        @(posedge clk); #1;
        check("a0_after_wb", a0, 32'd5);

        // 3. back-to-back with forwarding
        issue(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 4'd0, 32'd7, 1'b1);
        issue(5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1);
        check("fwd_result", bus.result, 32'd14);
        issue(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 4'd3, 32'd0, 1'b1);
        @(posedge clk); #1;

        // 4. stall: result held, new input ignored, single retire
        bus.out_ready = 1'b0;
        issue(5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 4'd4, 32'h0000_00f0, 1'b1);
        held = 32'h0000_00f7;
        bus.rs1 = 5'd2; bus.rd = 5'd7; bus.RegWrite = 1'b1; bus.ALUsrc = 1'b1;
        bus.ALUCtrl = 4'd0; bus.ImmOp = 32'h1234; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall_result", bus.result, held);
        end
        bus.in_valid = 1'b0;
        ret0 = retired;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stall_retire_once", 32'(retired - ret0), 32'd1);
        check("stall_drained", {31'd0, bus.out_valid}, 32'd0);
        issue(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 4'd3, 32'd0, 1'b1);
        issue(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 4'd3, 32'd0, 1'b1);

        // 5. ALU corner cases
        issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 4'd0, 32'h8000_0000, 1'b1);
        issue(5'd4, 5'd0, 5'd3, 1'b1, 1'b1, 4'd9, 32'd4, 1'b1);
        check("sra", bus.result, 32'hF800_0000);
        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b1);
        issue(5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 4'd5, 32'd1, 1'b1);
        check("slt", bus.result, 32'd1);
        issue(5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 4'd6, 32'd1, 1'b1);
        check("sltu", bus.result, 32'd0);
        issue(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 4'd0, 32'd3, 1'b1);
        issue(5'd6, 5'd0, 5'd0, 1'b0, 1'b1, 4'd1, 32'd3, 1'b1);
        check("sub_result", bus.result, 32'd0);
        check("sub_eq", {31'd0, bus.eq}, 32'd1);
        issue(5'd6, 5'd0, 5'd0, 1'b0, 1'b1, 4'd12, 32'd3, 1'b1);
        check("op12_result", bus.result, 32'd0);
        for (int i = 0; i < 10; i++) begin
            issue(5'($urandom_range(1, 6)), 5'($urandom_range(0, 6)), 5'($urandom_range(1, 4)),
                  1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 1'b1);
        end
        for (int i = 1; i < 7; i++) issue(5'(i), 5'd0, 5'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);

        // 6. x0 hardwired, reset drops pending write
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 4'd0, 32'd9, 1'b1);
        issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'd3, 32'd0, 1'b1);
        check("x0_read", bus.result, 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 4'd0, 32'd77, 1'b0);
        check("pending_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_drop_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_drop_result", bus.result, 32'd0);
        check("rst_a0_cleared", a0, 32'd0);
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        issue(5'd5, 5'd10, 5'd0, 1'b0, 1'b0, 4'd3, 32'd0, 1'b1);
        check("rst_x5_zero", bus.result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
